id_stage: RTL and testbench

- Instruction-decode stage of the 16-bit MIPS pipeline, directly upstream of the 8x16 register file.
- Decodes the IF/ID instruction and drives the register file's two read addresses combinationally.
- Applies writeback bypass to the read data and latches operands plus control into the ID/EX pipeline register.
- Detects load-use hazards, inserts bubbles, honours flush/stall from EX, and keeps a saturating stall counter.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/hazard_unit.sv | 22 ++
 rtl/id_stage.sv | 185 ++++++++++++++++++
 tb/tb_id_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Encoding constants and shared types for the 16-bit MIPS pipeline.
package mips_pkg;
  localparam int DATA_W_DEF     = 16;
  localparam int REG_ADDR_W_DEF = 3;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_J     = 4'h5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam int OPC_LSB = 12;
  localparam int OPC_W   = 4;
  localparam int RS_LSB  = 9;
  localparam int RT_LSB  = 6;
  localparam int RD_LSB  = 3;
  localparam int FN_LSB  = 0;
  localparam int FN_W    = 3;
  localparam int IMM6_W  = 6;
  localparam int JIMM_W  = 12;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
  } ctrl_t;

  // Instructions whose rt field is a source operand rather than a destination.
  function automatic logic uses_rt(input logic [OPC_W-1:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction
endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
module hazard_unit
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  id_valid,
  input  logic [OPC_W-1:0]      opcode,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  output logic                  hazard
);
  logic load_in_ex;

  // A load into R0 never produces a value anyone waits for.
  assign load_in_ex = ex_valid && ex_mem_read && (ex_dest != '0);
  assign hazard     = load_in_ex && id_valid &&
                      ((ex_dest == rs) || (uses_rt(opcode) && (ex_dest == rt)));
endmodule

// File: rtl/id_stage.sv
// Decode stage: register read addressing, writeback bypass, load-use stall and ID/EX register.
module id_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int PC_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_instr,
  input  logic [PC_W-1:0]       id_pc,
  output logic                  id_ready,
  output logic [REG_ADDR_W-1:0] rf_read_reg_1,
  output logic [REG_ADDR_W-1:0] rf_read_reg_2,
  input  logic [DATA_W-1:0]     rf_read_data_1,
  input  logic [DATA_W-1:0]     rf_read_data_2,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  ex_flush,
  input  logic                  ex_stall,
  output logic                  ex_valid,
  output logic [PC_W-1:0]       ex_pc,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic [2:0]            ex_alu_op,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic [15:0]           stall_count
);
  function automatic logic signed [DATA_W-1:0] sext_imm6(input logic signed [IMM6_W-1:0] imm);
    return DATA_W'(imm);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [DATA_W-1:0] bypass(input logic [REG_ADDR_W-1:0] addr,
                                               input logic [DATA_W-1:0]     rf_data,
                                               input logic                  wb_we,
                                               input logic [REG_ADDR_W-1:0] wb_addr,
                                               input logic [DATA_W-1:0]     wb_value);
    if (addr == '0)                      return '0;
    if (wb_we && (wb_addr == addr))      return wb_value;
    return rf_data;
  endfunction

  logic [OPC_W-1:0]           opcode;
  logic [REG_ADDR_W-1:0]      rs, rt, rd;
  logic [FN_W-1:0]            funct;
  logic                       hazard;
  logic                       load_p0, kill_p0;

  logic [REG_ADDR_W-1:0]      dec_dest_p0;
  ctrl_t                      dec_ctrl_p0;
  logic signed [DATA_W-1:0]   dec_imm_p0;
  logic [DATA_W-1:0]          opa_p0, opb_p0;

  logic                       vld_p1;
  logic [PC_W-1:0]            pc_p1;
  logic [DATA_W-1:0]          rs_data_p1, rt_data_p1, imm_p1;
  logic [REG_ADDR_W-1:0]      dest_p1;
  ctrl_t                      ctrl_p1;
  logic [15:0]                stall_cnt;

  assign opcode = id_instr[OPC_LSB +: OPC_W];
  assign rs     = id_instr[RS_LSB +: REG_ADDR_W];
  assign rt     = id_instr[RT_LSB +: REG_ADDR_W];
  assign rd     = id_instr[RD_LSB +: REG_ADDR_W];
  assign funct  = id_instr[FN_LSB +: FN_W];

  assign rf_read_reg_1 = rs;
  assign rf_read_reg_2 = rt;

  always_comb begin
    dec_dest_p0 = '0;
    dec_ctrl_p0 = '0;
    dec_imm_p0  = sext_imm6(id_instr[IMM6_W-1:0]);
    case (opcode)
      OP_RTYPE: begin
        dec_dest_p0           = rd;
        dec_ctrl_p0.alu_op    = funct;
        dec_ctrl_p0.reg_write = 1'b1;
      end
      OP_ADDI: begin
        dec_dest_p0           = rt;
        dec_ctrl_p0.alu_op    = ALU_ADD;
        dec_ctrl_p0.alu_src   = 1'b1;
        dec_ctrl_p0.reg_write = 1'b1;
      end
      OP_LW: begin
        dec_dest_p0           = rt;
        dec_ctrl_p0.alu_op    = ALU_ADD;
        dec_ctrl_p0.alu_src   = 1'b1;
        dec_ctrl_p0.mem_read  = 1'b1;
        dec_ctrl_p0.reg_write = 1'b1;
      end
      OP_SW: begin
        dec_ctrl_p0.alu_op    = ALU_ADD;
        dec_ctrl_p0.alu_src   = 1'b1;
        dec_ctrl_p0.mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl_p0.alu_op = ALU_SUB;
        dec_ctrl_p0.branch = 1'b1;
      end
      OP_J: begin
        dec_ctrl_p0.jump = 1'b1;
        dec_imm_p0       = DATA_W'(id_instr[JIMM_W-1:0]);
      end
      default: ;
    endcase
  end

  assign opa_p0 = bypass(rs, rf_read_data_1, wb_reg_write, wb_dest, wb_data);
  assign opb_p0 = bypass(rt, rf_read_data_2, wb_reg_write, wb_dest, wb_data);

  hazard_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .ex_valid    (vld_p1),
    .ex_mem_read (ctrl_p1.mem_read),
    .ex_dest     (dest_p1),
    .id_valid    (id_valid),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .hazard      (hazard)
  );

  assign id_ready = !rst && !ex_stall && !hazard;
  // Flush overrides a stall from EX; otherwise EX stall holds everything.
  assign kill_p0  = ex_flush || (!ex_stall && (hazard || !id_valid));
  assign load_p0  = !ex_flush && !ex_stall && !hazard && id_valid;

  // ---- ID/EX boundary ----
  always_ff @(posedge clk) begin
    if (rst || kill_p0) begin
      vld_p1     <= 1'b0;
      pc_p1      <= '0;
      rs_data_p1 <= '0;
      rt_data_p1 <= '0;
      imm_p1     <= '0;
      dest_p1    <= '0;
      ctrl_p1    <= '0;
    end else if (load_p0) begin
      vld_p1     <= 1'b1;
      pc_p1      <= id_pc;
      rs_data_p1 <= opa_p0;
      rt_data_p1 <= opb_p0;
      imm_p1     <= dec_imm_p0;
      dest_p1    <= dec_dest_p0;
      ctrl_p1    <= dec_ctrl_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (hazard && !ex_stall && !ex_flush)
      stall_cnt <= sat_inc(stall_cnt);
  end

  assign ex_valid     = vld_p1;
  assign ex_pc        = pc_p1;
  assign ex_rs_data   = rs_data_p1;
  assign ex_rt_data   = rt_data_p1;
  assign ex_imm       = imm_p1;
  assign ex_dest      = dest_p1;
  assign ex_alu_op    = ctrl_p1.alu_op;
  assign ex_alu_src   = ctrl_p1.alu_src;
  assign ex_reg_write = ctrl_p1.reg_write;
  assign ex_mem_read  = ctrl_p1.mem_read;
  assign ex_mem_write = ctrl_p1.mem_write;
  assign ex_branch    = ctrl_p1.branch;
  assign ex_jump      = ctrl_p1.jump;
  assign stall_count  = stall_cnt;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [15:0] id_instr, id_pc;
  logic        id_ready;
  logic [2:0]  rf_read_reg_1, rf_read_reg_2;
  logic [15:0] rf_read_data_1, rf_read_data_2;
  logic        wb_reg_write;
  logic [2:0]  wb_dest;
  logic [15:0] wb_data;
  logic        ex_flush, ex_stall;
  logic        ex_valid;
  logic [15:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [2:0]  ex_dest, ex_alu_op;
  logic        ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump;
  logic [15:0] stall_count;

  id_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_ready(id_ready), .rf_read_reg_1(rf_read_reg_1), .rf_read_reg_2(rf_read_reg_2),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_data(wb_data),
    .ex_flush(ex_flush), .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_dest(ex_dest),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  logic [15:0] regs [8];
  assign rf_read_data_1 = regs[rf_read_reg_1];
  assign rf_read_data_2 = regs[rf_read_reg_2];

  typedef struct packed {
    logic        valid;
    logic [15:0] pc, a, b, imm;
    logic [2:0]  dest, alu_op;
    logic        alu_src, rw, mr, mw, br, jp;
  } exp_t;

  exp_t        exp_q;
  int unsigned stall_m;
  int          checks = 0;
  int          errors = 0;
  logic        obs_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] rd_model(input logic [2:0] r);
    if (r == 3'd0) return 16'h0;
    if (wb_reg_write && wb_dest == r) return wb_data;
    return regs[r];
  endfunction

  function automatic exp_t model_decode(input logic [15:0] ins, input logic [15:0] pc,
                                        input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e       = '0;
    e.valid = 1'b1;
    e.pc    = pc;
    e.a     = a;
    e.b     = b;
    e.imm   = {{10{ins[5]}}, ins[5:0]};
    case (ins[15:12])
      4'h0: begin e.dest = ins[5:3]; e.alu_op = ins[2:0]; e.rw = 1'b1; end
      4'h1: begin e.dest = ins[8:6]; e.alu_src = 1'b1; e.rw = 1'b1; end
      4'h2: begin e.dest = ins[8:6]; e.alu_src = 1'b1; e.mr = 1'b1; e.rw = 1'b1; end
      4'h3: begin e.alu_src = 1'b1; e.mw = 1'b1; end
      4'h4: begin e.br = 1'b1; e.alu_op = 3'b001; end
      4'h5: begin e.jp = 1'b1; e.imm = {4'h0, ins[11:0]}; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check_ex();
    check("ex_valid", 32'(ex_valid), 32'(exp_q.valid));
    check("ex_reg_write", 32'(ex_reg_write), 32'(exp_q.rw));
    check("ex_mem_read", 32'(ex_mem_read), 32'(exp_q.mr));
    check("ex_mem_write", 32'(ex_mem_write), 32'(exp_q.mw));
    check("ex_branch", 32'(ex_branch), 32'(exp_q.br));
    check("ex_jump", 32'(ex_jump), 32'(exp_q.jp));
    check("ex_alu_src", 32'(ex_alu_src), 32'(exp_q.alu_src));
    if (exp_q.valid) begin
      check("ex_pc", 32'(ex_pc), 32'(exp_q.pc));
      check("ex_rs_data", 32'(ex_rs_data), 32'(exp_q.a));
      check("ex_rt_data", 32'(ex_rt_data), 32'(exp_q.b));
      check("ex_imm", 32'(ex_imm), 32'(exp_q.imm));
      if (exp_q.rw) check("ex_dest", 32'(ex_dest), 32'(exp_q.dest));
      if ((exp_q.rw && !exp_q.mr) || exp_q.br)
        check("ex_alu_op", 32'(ex_alu_op), 32'(exp_q.alu_op));
    end
    check("stall_count", 32'(stall_count), stall_m);
  endtask

  // One clock: check combinational outputs, predict, clock, then check the ID/EX register.
  task automatic cycle();
    exp_t       nxt;
    logic       haz, urt;
    logic [2:0] rs, rt;
    logic [3:0] op;
    #1;
    op  = id_instr[15:12];
    rs  = id_instr[11:9];
    rt  = id_instr[8:6];
    urt = (op == 4'h0) || (op == 4'h3) || (op == 4'h4);
    haz = exp_q.valid && exp_q.mr && (exp_q.dest != 3'd0) && id_valid &&
          ((exp_q.dest == rs) || (urt && exp_q.dest == rt));
    check("rf_read_reg_1", 32'(rf_read_reg_1), 32'(rs));
    check("rf_read_reg_2", 32'(rf_read_reg_2), 32'(rt));
    check("id_ready", 32'(id_ready), 32'(!rst && !ex_stall && !haz));
    obs_ready = id_ready;
    if (rst || ex_flush)          nxt = '0;
    else if (ex_stall)            nxt = exp_q;
    else if (haz || !id_valid)    nxt = '0;
    else                          nxt = model_decode(id_instr, id_pc, rd_model(rs), rd_model(rt));
    if (rst) stall_m = 0;
    else if (haz && !ex_stall && !ex_flush && stall_m < 32'hFFFF) stall_m++;
    @(posedge clk);
    #1;
    if (wb_reg_write && wb_dest != 3'd0) regs[wb_dest] = wb_data;
    exp_q = nxt;
    @(negedge clk);
    check_ex();
  endtask

  task automatic drive(input logic v, input logic [15:0] ins, input logic st, input logic fl,
                       input logic we, input logic [2:0] wd, input logic [15:0] wdat);
    id_valid     = v;
    id_instr     = ins;
    id_pc        = 16'($urandom);
    ex_stall     = st;
    ex_flush     = fl;
    wb_reg_write = we;
    wb_dest      = wd;
    wb_data      = wdat;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] ops [9];
    ops = '{4'h0, 4'h1, 4'h2, 4'h2, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9};
    return {ops[$urandom_range(0, 8)], 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            6'($urandom)};
  endfunction

  int unsigned saved;

  initial begin
    regs[0] = 16'h0;
    regs[1] = 16'h0001;
    for (int i = 2; i < 8; i++) regs[i] = 16'($urandom);
    exp_q   = '0;
    stall_m = 0;
    @(negedge clk);

    // Reset held two cycles while IF presents a valid instruction.
    rst = 1'b1;
    drive(1'b1, 16'h22C0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    cycle();
    cycle();
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_count", 32'(stall_count), 32'd0);
    rst = 1'b0;

    // ADDI R2,R1,-3 latched on the first cycle out of reset.
    drive(1'b1, 16'h12BD, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    cycle();
    check("addi_imm", 32'(ex_imm), 32'hFFFD);
    check("addi_rs", 32'(ex_rs_data), 32'h1);
    check("addi_dest", 32'(ex_dest), 32'd2);
    check("addi_src", 32'(ex_alu_src), 32'd1);

    // LW R3 then dependent ADD R4,R3,R1.
    drive(1'b1, 16'h22C0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    cycle();
    saved = stall_m;
    drive(1'b1, 16'h0660, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    cycle();
    check("lu_ready", 32'(obs_ready), 32'd0);
    check("lu_bubble", 32'(ex_valid), 32'd0);
    check("lu_count", 32'(stall_count), saved + 1);
    cycle();
    check("lu_add_valid", 32'(ex_valid), 32'd1);
    check("lu_add_dest", 32'(ex_dest), 32'd4);

    // Writeback bypass onto rs, and no bypass for R0.
    drive(1'b1, 16'h1B80, 1'b0, 1'b0, 1'b1, 3'd5, 16'hBEEF);
    cycle();
    check("byp_rs", 32'(ex_rs_data), 32'hBEEF);
    drive(1'b1, 16'h1180, 1'b0, 1'b0, 1'b1, 3'd0, 16'hBEEF);
    cycle();
    check("byp_r0", 32'(ex_rs_data), 32'h0);

    // EX stall for three cycles with a waiting instruction.
    drive(1'b1, 16'h0660, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_ready", 32'(obs_ready), 32'd0);
    end
    ex_stall = 1'b0;
    cycle();

    // Flush coincident with a load-use hazard.
    drive(1'b1, 16'h22C0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    cycle();
    saved = stall_m;
    drive(1'b1, 16'h0660, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0);
    cycle();
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_count", 32'(stall_count), saved);

    // Saturation of the stall counter.
    force dut.stall_cnt = 16'hFFFE;
    #1;
    release dut.stall_cnt;
    stall_m = 32'hFFFE;
    check("sat_preset", 32'(stall_count), 32'hFFFE);
    drive(1'b1, 16'h2240, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
    for (int i = 0; i < 7; i++) cycle();
    check("sat_count", 32'(stall_count), 32'hFFFF);

    // Randomized traffic; IF holds its instruction whenever ID did not accept it.
    for (int i = 0; i < 600; i++) begin
      if (!(id_valid && !obs_ready && !ex_flush)) begin
        id_valid = ($urandom_range(0, 7) != 0);
        id_instr = rand_instr();
        id_pc    = 16'($urandom);
      end
      ex_stall     = ($urandom_range(0, 5) == 0);
      ex_flush     = ($urandom_range(0, 9) == 0);
      wb_reg_write = 1'($urandom_range(0, 1));
      wb_dest      = 3'($urandom);
      wb_data      = 16'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
